vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 800x600@60 defaults, counter widths,
// and the axis-total helper used by timing and drawing blocks.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BP_DEF     = 88;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BP_DEF     = 23;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF; // 1056
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF; // 628

    localparam int HCNT_W  = 11;
    localparam int VCNT_W  = 10;
    localparam int FRAME_W = 16;

    // Largest totals the counter widths can represent.
    localparam int H_TOTAL_MAX = 2048;
    localparam int V_TOTAL_MAX = 1024;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrapping position counter for one VGA axis. Blank/sync flags are
// decoded from the next count so they line up with the count register.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int W        = HCNT_W,
    parameter int ACTIVE   = H_ACTIVE_DEF,
    parameter int FP       = H_FP_DEF,
    parameter int SYNC     = H_SYNC_DEF,
    parameter int BP       = H_BP_DEF,
    parameter bit SYNC_POS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,       // asynchronous, active-low
    input  logic         adv,       // advance one position this clock
    output logic [W-1:0] count,
    output logic         last,      // count is at TOTAL-1
    output logic         blank,
    output logic         sync,
    output logic         zero_nxt   // count will be zero after this clock
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST_C    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_C  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO_C = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI_C = W'(ACTIVE + FP + SYNC - 1);

    logic [W-1:0] count_q, count_d;
    logic         blank_q, blank_d;
    logic         sync_q, sync_d;

    // Next count and the decodes that belong to it.
    always_comb begin
        count_d = count_q;
        if (adv) begin
            count_d = (count_q == LAST_C) ? '0 : count_q + 1'b1;
        end
        blank_d = (count_d >= ACTIVE_C);
        sync_d  = ((count_d >= SYNC_LO_C) && (count_d <= SYNC_HI_C)) ? SYNC_POS : ~SYNC_POS;
    end

    // Count and decode registers; reset parks the axis at position 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= ~SYNC_POS;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count    = count_q;
    assign last     = (count_q == LAST_C);
    assign blank    = blank_q;
    assign sync     = sync_q;
    assign zero_nxt = (count_d == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical position counters,
// blank/sync decodes, line/frame start markers and a completed-frame counter.
// Every output is a register with zero skew relative to hcount/vcount.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,         // asynchronous, active-low
    input  logic               en,
    output logic [HCNT_W-1:0]  hcount,
    output logic [VCNT_W-1:0]  vcount,
    output logic               hblnk,
    output logic               vblnk,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Totals that overflow the fixed counter widths are rejected at elaboration.
    if (H_TOT > H_TOTAL_MAX) begin : g_h_total_too_big
        $error("vga_timing_gen: horizontal total exceeds 2048");
    end
    if (V_TOT > V_TOTAL_MAX) begin : g_v_total_too_big
        $error("vga_timing_gen: vertical total exceeds 1024");
    end

    logic h_last, h_zero_nxt;
    logic v_last, v_zero_nxt;

    vga_axis_counter #(
        .W(HCNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .SYNC_POS(SYNC_POS)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .adv      (en),
        .count    (hcount),
        .last     (h_last),
        .blank    (hblnk),
        .sync     (hsync),
        .zero_nxt (h_zero_nxt)
    );

    // The vertical axis steps only on the clock where the line wraps.
    vga_axis_counter #(
        .W(VCNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .SYNC_POS(SYNC_POS)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .adv      (en & h_last),
        .count    (vcount),
        .last     (v_last),
        .blank    (vblnk),
        .sync     (vsync),
        .zero_nxt (v_zero_nxt)
    );

    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    // Start markers follow the next position; frame count bumps on full wrap.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = h_zero_nxt;
        frame_start_d = h_zero_nxt & v_zero_nxt;
        if (en && h_last && v_last) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Marker and frame-count registers; reset lands on position (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q   <= '0;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance (dut) and a small,
// active-low-sync instance (dut_s) share clock, reset and enable. A raster
// position model predicts every output each cycle; directed phases pin
// reset, line timing, frame wrap, stall, mid-frame reset and counter wrap.
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic [10:0] h0, h1;
    logic [9:0]  v0, v1;
    logic        hb0, vb0, hs0, vs0, ls0, fs0;
    logic        hb1, vb1, hs1, vs1, ls1, fs1;
    logic [15:0] fc0, fc1;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .en(en),
        .hcount(h0), .vcount(v0), .hblnk(hb0), .vblnk(vb0),
        .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0),
        .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POS(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en),
        .hcount(h1), .vcount(v1), .hblnk(hb1), .vblnk(vb1),
        .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1),
        .frame_cnt(fc1)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b1;

    task automatic cmp(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- raster model ----------------
    localparam int HA [2] = '{800, 16};
    localparam int HF [2] = '{40, 2};
    localparam int HS [2] = '{128, 4};
    localparam int HB [2] = '{88, 3};
    localparam int VA [2] = '{600, 10};
    localparam int VF [2] = '{1, 1};
    localparam int VS [2] = '{4, 2};
    localparam int VB [2] = '{23, 2};
    localparam int SP [2] = '{1, 0};

    int       mh [2];
    int       mv [2];
    bit [15:0] mf [2];
    bit       preload_req = 1'b0;

    function automatic int ht(input int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int vt(input int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    // Position of each raster after every clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mh[i] <= 0;
                mv[i] <= 0;
                mf[i] <= '0;
            end
        end else begin
            if (preload_req) mf[1] <= 16'hFFFF;
            if (en) begin
                for (int i = 0; i < 2; i++) begin
                    if (mh[i] == ht(i) - 1) begin
                        mh[i] <= 0;
                        if (mv[i] == vt(i) - 1) begin
                            mv[i] <= 0;
                            mf[i] <= mf[i] + 16'd1;
                        end else begin
                            mv[i] <= mv[i] + 1;
                        end
                    end else begin
                        mh[i] <= mh[i] + 1;
                    end
                end
            end
        end
    end

    task automatic check_inst(input int i, input string p, input int h, input int v,
                              input logic hb, input logic vb, input logic hs,
                              input logic vs, input logic ls, input logic fs,
                              input logic [15:0] fc);
        int h_in_sync;
        int v_in_sync;
        h_in_sync = (mh[i] >= HA[i] + HF[i]) && (mh[i] < HA[i] + HF[i] + HS[i]);
        v_in_sync = (mv[i] >= VA[i] + VF[i]) && (mv[i] < VA[i] + VF[i] + VS[i]);
        cmp({p, ".hcount"},      h,  mh[i]);
        cmp({p, ".vcount"},      v,  mv[i]);
        cmp({p, ".hblnk"},       int'(hb), int'(mh[i] >= HA[i]));
        cmp({p, ".vblnk"},       int'(vb), int'(mv[i] >= VA[i]));
        cmp({p, ".hsync"},       int'(hs), h_in_sync ? SP[i] : 1 - SP[i]);
        cmp({p, ".vsync"},       int'(vs), v_in_sync ? SP[i] : 1 - SP[i]);
        cmp({p, ".line_start"},  int'(ls), int'(mh[i] == 0));
        cmp({p, ".frame_start"}, int'(fs), int'(mh[i] == 0 && mv[i] == 0));
        cmp({p, ".frame_cnt"},   int'(fc), int'(mf[i]));
    endtask

    // Compare process: every output of both instances, every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_inst(0, "dflt", int'(h0), int'(v0), hb0, vb0, hs0, vs0, ls0, fs0, fc0);
            check_inst(1, "small", int'(h1), int'(v1), hb1, vb1, hs1, vs1, ls1, fs1, fc1);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int first_blank, sync_first, sync_last, sync_cnt, prev_h, prev_v;

        // Reset held for 5 clocks with en high.
        rst = 1'b0;
        en  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        cmp("rst.hcount", int'(h0), 0);
        cmp("rst.vcount", int'(v0), 0);
        cmp("rst.hsync", int'(hs0), 0);
        cmp("rst.frame_start", int'(fs0), 1);
        cmp("rst.line_start", int'(ls0), 1);
        cmp("rst.small_hsync_inactive_high", int'(hs1), 1);

        // Release: hcount walks 1,2,3.
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cmp("release.hcount", int'(h0), k);
            cmp("release.small_hcount", int'(h1), k);
        end

        // One full line on the default instance.
        first_blank = -1; sync_first = -1; sync_last = -1; sync_cnt = 0; prev_h = -1;
        n = 0;
        while (h0 != 0 && n < 1100) begin
            prev_h = int'(h0);
            @(negedge clk);
            n++;
            if (hb0 && first_blank < 0) first_blank = int'(h0);
            if (hs0) begin
                if (sync_first < 0) sync_first = int'(h0);
                sync_last = int'(h0);
                sync_cnt++;
            end
        end
        cmp("line.wrap_reached", int'(h0 == 0), 1);
        cmp("line.hblnk_rise", first_blank, 800);
        cmp("line.hsync_first", sync_first, 840);
        cmp("line.hsync_last", sync_last, 967);
        cmp("line.hsync_width", sync_cnt, 128);
        cmp("line.prev_hcount", prev_h, 1055);
        cmp("line.vcount_after_wrap", int'(v0), 1);

        // Stall at hcount 500 for 10 clocks.
        n = 0;
        while (h0 != 11'd500 && n < 600) begin
            @(negedge clk);
            n++;
        end
        cmp("stall.reached", int'(h0), 500);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cmp("stall.hcount_held", int'(h0), 500);
            cmp("stall.vcount_held", int'(v0), 1);
        end
        en = 1'b1;
        @(negedge clk);
        cmp("stall.resume_hcount", int'(h0), 501);

        // Frame wrap on the small instance, starting from a fresh reset.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sync_first = -1; sync_last = -1; sync_cnt = 0; prev_h = -1; prev_v = -1;
        n = 0;
        while (fc1 == 16'd0 && n < 400) begin
            prev_h = int'(h1);
            prev_v = int'(v1);
            @(negedge clk);
            n++;
            if (!vs1) begin
                if (sync_first < 0) sync_first = int'(v1);
                sync_last = int'(v1);
                sync_cnt++;
            end
        end
        cmp("frame.frame_cnt", int'(fc1), 1);
        cmp("frame.prev_hcount", prev_h, 24);
        cmp("frame.prev_vcount", prev_v, 14);
        cmp("frame.hcount", int'(h1), 0);
        cmp("frame.vcount", int'(v1), 0);
        cmp("frame.frame_start", int'(fs1), 1);
        cmp("frame.vsync_first_line", sync_first, 11);
        cmp("frame.vsync_last_line", sync_last, 12);
        cmp("frame.vsync_cycles", sync_cnt, 50);

        // Mid-frame asynchronous reset at (10,7) with frame_cnt = 3.
        n = 0;
        while (!(fc1 == 16'd3 && h1 == 11'd10 && v1 == 10'd7) && n < 1500) begin
            @(negedge clk);
            n++;
        end
        cmp("midrst.reached", int'(fc1 == 16'd3 && h1 == 11'd10 && v1 == 10'd7), 1);
        #2;
        rst = 1'b0;
        #1;
        cmp("midrst.hcount", int'(h1), 0);
        cmp("midrst.vcount", int'(v1), 0);
        cmp("midrst.frame_cnt", int'(fc1), 0);
        cmp("midrst.hsync", int'(hs1), 1);
        cmp("midrst.vsync", int'(vs1), 1);
        cmp("midrst.frame_start", int'(fs1), 1);
        cmp("midrst.dflt_hcount", int'(h0), 0);
        cmp("midrst.dflt_hsync", int'(hs0), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp("midrst.release_hcount", int'(h1), 1);
        cmp("midrst.release_frame_cnt", int'(fc1), 0);

        // Preload frame_cnt to 0xFFFF and let one frame end.
        cmp_en = 1'b0;
        en = 1'b0;
        force dut_s.frame_cnt_q = 16'hFFFF;
        preload_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        release dut_s.frame_cnt_q;
        preload_req = 1'b0;
        cmp("wrap.preload", int'(fc1), 16'hFFFF);
        cmp_en = 1'b1;
        en = 1'b1;
        n = 0;
        while (fc1 == 16'hFFFF && n < 400) begin
            @(negedge clk);
            n++;
        end
        cmp("wrap.frame_cnt", int'(fc1), 0);
        cmp("wrap.hcount", int'(h1), 0);
        cmp("wrap.vcount", int'(v1), 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
